serial_word_feeder: RTL

Parallel-to-serial front end for the bit-serial sequence detectors. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on `j`, MSB-first or LSB-first. `j` drives the detector's `j` input directly. Back-to-back words stream with no gap cycle, and a wrapping count of completed words is kept for the bench.

---
 rtl/serial_word_feeder.sv | 59 +++++
 1 files changed

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: valid/ready word loader that shifts each word out one bit per clock on j
module serial_word_feeder #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0,
  parameter int   CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             msb_first,
  output logic             ready,
  output logic             j,
  output logic             bit_valid,
  output logic             last,
  output logic [CNT_W-1:0] words_sent
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             ord_q;
  logic [CW-1:0]    cnt_q;
  logic [CNT_W-1:0] words_q;
  logic             at_end, accept;
  // Decode handshake and serial outputs purely from registered state; load only gates accept.
  always_comb begin
    at_end     = state_q == SHIFT && cnt_q == CW'(WIDTH - 1);
    ready      = state_q == IDLE || at_end;
    accept     = load && ready;
    sr_d       = ord_q ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    j          = state_q == SHIFT ? (ord_q ? sr_q[WIDTH-1] : sr_q[0]) : IDLE_BIT;
    bit_valid  = state_q == SHIFT;
    last       = at_end;
    words_sent = words_q;
  end
  // Load on accept, otherwise shift until the final bit, then reload gaplessly or fall idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      ord_q   <= 1'b1;
      cnt_q   <= '0;
      words_q <= '0;
    end else begin
      if (at_end) words_q <= words_q + CNT_W'(1);
      if (accept) begin
        sr_q    <= din;
        ord_q   <= msb_first;
        cnt_q   <= '0;
        state_q <= SHIFT;
      end else if (state_q == SHIFT) begin
        if (at_end) state_q <= IDLE;
        sr_q  <= sr_d;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule
